// File: rtl/pulse_seq_pkg.sv
// Shared types for the pulse sequence scheduler.
// Holds the state enum, symbol struct and default widths.
package pulse_seq_pkg;

  localparam int P_DUR_W = 8;
  localparam int P_PRE_W = 8;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  typedef struct packed {
    logic               last;
    logic               level;
    logic [P_DUR_W-1:0] dur;
  } sym_t;

endpackage

// File: rtl/pulse_seq_tick_gen.sv
// Divider: counts 0..i_div and pulses o_tick on the wrap cycle.
// Used both as the symbol prescaler and as the carrier divider.
module pulse_seq_tick_gen #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic [W-1:0] i_div,
  output logic         o_tick
);

  logic [W-1:0] r_cnt;

  // >= so a lowered divisor mid-count still wraps at once
  assign o_tick = (r_cnt >= i_div);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt <= '0;
    end else if (i_clr || o_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/pulse_seq_scheduler.sv
// Pulse sequence scheduler: plays {last, level, dur} symbols on pulse_out.
// Optional carrier modulation of high symbols under PULSE_SEQ_CARRIER_EN.
module pulse_seq_scheduler
  import pulse_seq_pkg::*;
#(
  parameter int DUR_W = P_DUR_W,
  parameter int PRE_W = P_PRE_W
) (
  input  logic             clk,
  input  logic             sys_rst,
  input  logic             en_i,
  input  logic [PRE_W-1:0] prescale_i,
  input  logic             idle_level_i,
  input  logic             sym_valid_i,
  output logic             sym_ready_o,
  input  logic             sym_level_i,
  input  logic [DUR_W-1:0] sym_dur_i,
  input  logic             sym_last_i,
`ifdef PULSE_SEQ_CARRIER_EN
  input  logic [PRE_W-1:0] carrier_div_i,
`endif
  output logic             pulse_out,
  output logic             rise_o,
  output logic             fall_o,
  output logic             busy_o,
  output logic             done_o,
  output logic             underrun_o
);

  state_t r_state;
  state_t w_next;
  sym_t   r_cur;
  logic   r_prev;

  logic w_en;
  logic w_tick;
  logic w_bound;
  logic w_load;
  logic w_done;
  logic w_under;
  logic w_lvl;
  logic w_drive;
  logic w_pre_clr;

  // Ready must read 0 while reset is held
  assign w_en      = en_i & ~sys_rst;
  assign w_bound   = (r_state == RUN) & w_tick & (r_cur.dur == '0);
  assign w_pre_clr = ((r_state == IDLE) & w_load) | ~w_en;
  assign w_lvl     = w_load ? sym_level_i : r_cur.level;
  assign busy_o    = (r_state == RUN);

  pulse_seq_tick_gen #(.W(PRE_W)) u_pre (
    .clk    (clk),
    .rst    (sys_rst),
    .i_clr  (w_pre_clr),
    .i_div  (prescale_i),
    .o_tick (w_tick)
  );

`ifdef PULSE_SEQ_CARRIER_EN
  logic w_ctick;
  logic w_car;
  logic r_car;

  pulse_seq_tick_gen #(.W(PRE_W)) u_car (
    .clk    (clk),
    .rst    (sys_rst),
    .i_clr  (w_load | ~w_en),
    .i_div  (carrier_div_i),
    .o_tick (w_ctick)
  );

  assign w_car   = w_load ? 1'b1 : (w_ctick ? ~r_car : r_car);
  assign w_drive = w_lvl & w_car;

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_car <= 1'b1;
    end else begin
      r_car <= w_car;
    end
  end
`else
  assign w_drive = w_lvl;
`endif

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_done      = 1'b0;
    w_under     = 1'b0;
    sym_ready_o = 1'b0;
    if (!w_en) begin
      w_next = IDLE;
    end else begin
      unique case (r_state)
        IDLE: begin
          sym_ready_o = 1'b1;
          if (sym_valid_i) begin
            w_load = 1'b1;
            w_next = RUN;
          end
        end
        RUN: begin
          if (w_bound) begin
            if (r_cur.last) begin
              w_next = IDLE;
              w_done = 1'b1;
            end else if (sym_valid_i) begin
              sym_ready_o = 1'b1;
              w_load      = 1'b1;
            end else begin
              w_next  = IDLE;
              w_under = 1'b1;
            end
          end
        end
        default: w_next = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge sys_rst) begin
    if (sys_rst) begin
      r_state    <= IDLE;
      r_cur      <= '0;
      pulse_out  <= 1'b0;
      r_prev     <= 1'b0;
      rise_o     <= 1'b0;
      fall_o     <= 1'b0;
      done_o     <= 1'b0;
      underrun_o <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_cur.last  <= sym_last_i;
        r_cur.level <= sym_level_i;
        r_cur.dur   <= P_DUR_W'(sym_dur_i);
      end else if (w_en && busy_o && w_tick && r_cur.dur != '0) begin
        r_cur.dur <= r_cur.dur - 1'b1;
      end
      pulse_out  <= (w_next == RUN) ? w_drive : idle_level_i;
      r_prev     <= pulse_out;
      rise_o     <= pulse_out & ~r_prev;
      fall_o     <= ~pulse_out & r_prev;
      done_o     <= w_done;
      underrun_o <= w_under;
    end
  end

endmodule

// File: tb/tb_pulse_seq_scheduler.sv
// Self-checking bench for pulse_seq_scheduler (default build).
// Expected waveforms are built from symbol widths by plain arithmetic.
module tb_pulse_seq_scheduler;

  logic       clk = 1'b0;
  logic       sys_rst;
  logic       en_i;
  logic [7:0] prescale_i;
  logic       idle_level_i;
  logic       sym_valid_i;
  logic       sym_ready_o;
  logic       sym_level_i;
  logic [7:0] sym_dur_i;
  logic       sym_last_i;
  logic       pulse_out;
  logic       rise_o;
  logic       fall_o;
  logic       busy_o;
  logic       done_o;
  logic       underrun_o;

  pulse_seq_scheduler dut (
    .clk          (clk),
    .sys_rst      (sys_rst),
    .en_i         (en_i),
    .prescale_i   (prescale_i),
    .idle_level_i (idle_level_i),
    .sym_valid_i  (sym_valid_i),
    .sym_ready_o  (sym_ready_o),
    .sym_level_i  (sym_level_i),
    .sym_dur_i    (sym_dur_i),
    .sym_last_i   (sym_last_i),
    .pulse_out    (pulse_out),
    .rise_o       (rise_o),
    .fall_o       (fall_o),
    .busy_o       (busy_o),
    .done_o       (done_o),
    .underrun_o   (underrun_o)
  );

  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // Scenario: mode 0 = completes, 1 = underrun, 2 = abort at cycle abort_at
  int   n;
  int   mode;
  int   abort_at;
  int   tot;
  logic idle;
  int   dur [8];
  logic lvl [8];
  int   endc [8];
  logic pinv [0:1023];

  task automatic chk(input string tag, input logic obs, input logic exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s observed=%b expected=%b t=%0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic epin(input int c);
    if (c <= 0) return idle;
    if (mode == 2 && c > abort_at) return idle;
    if (c > tot) return idle;
    return pinv[c];
  endfunction

  function automatic logic eready(input int c);
    if (c == 0) return 1'b1;
    if (mode == 2 && c >= abort_at) return 1'b0;
    if (c > tot) return 1'b1;
    for (int i = 0; i < n - 1; i++)
      if (c == endc[i]) return 1'b1;
    return 1'b0;
  endfunction

  task automatic run(input int p);
    int c;
    int idx;
    int wend;
    c = 1;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < (dur[i] + 1) * (p + 1); k++) begin
        pinv[c] = lvl[i];
        c++;
      end
      endc[i] = c - 1;
    end
    tot = c - 1;
    if (mode == 2 && abort_at > tot) abort_at = tot;
    @(negedge clk);
    en_i         = 1'b1;
    sym_valid_i  = 1'b0;
    idle_level_i = idle;
    prescale_i   = 8'(p);
    repeat (4) @(negedge clk);
    idx  = 0;
    wend = ((mode == 2) ? abort_at : tot) + 3;
    for (int cy = 0; cy <= wend; cy++) begin
      @(negedge clk);
      en_i = !(mode == 2 && cy >= abort_at);
      if (idx < n) begin
        sym_valid_i = 1'b1;
        sym_level_i = lvl[idx];
        sym_dur_i   = 8'(dur[idx]);
        sym_last_i  = (mode != 1) && (idx == n - 1);
      end else begin
        sym_valid_i = 1'b0;
        sym_level_i = 1'b0;
        sym_dur_i   = 8'd0;
        sym_last_i  = 1'b0;
      end
      #1;
      chk("pin", pulse_out, epin(cy));
      chk("rise", rise_o, epin(cy - 1) & ~epin(cy - 2));
      chk("fall", fall_o, ~epin(cy - 1) & epin(cy - 2));
      chk("busy", busy_o,
          cy >= 1 && cy <= tot && !(mode == 2 && cy > abort_at));
      chk("done", done_o, mode == 0 && cy == tot + 1);
      chk("underrun", underrun_o, mode == 1 && cy == tot + 1);
      chk("ready", sym_ready_o, eready(cy));
      if (sym_valid_i && eready(cy)) idx++;
    end
    @(negedge clk);
    en_i        = 1'b1;
    sym_valid_i = 1'b0;
  endtask

  initial begin
    sys_rst      = 1'b0;
    en_i         = 1'b1;
    prescale_i   = 8'd0;
    idle_level_i = 1'b0;
    sym_valid_i  = 1'b0;
    sym_level_i  = 1'b0;
    sym_dur_i    = 8'd0;
    sym_last_i   = 1'b0;
    #1 sys_rst = 1'b1;
    #3;
    chk("rst_pin", pulse_out, 1'b0);
    chk("rst_busy", busy_o, 1'b0);
    chk("rst_ready", sym_ready_o, 1'b0);
    chk("rst_done", done_o, 1'b0);
    chk("rst_under", underrun_o, 1'b0);
    chk("rst_rise", rise_o, 1'b0);
    repeat (2) @(negedge clk);
    sys_rst = 1'b0;
    #1;
    chk("post_rst_ready", sym_ready_o, 1'b1);

    // Single 6-clk pulse
    n = 1; mode = 0; idle = 1'b0; abort_at = 0;
    dur[0] = 2; lvl[0] = 1'b1;
    run(1);

    // Back-to-back 1/2/3 clk symbols
    n = 3; mode = 0; idle = 1'b0;
    dur[0] = 0; lvl[0] = 1'b1;
    dur[1] = 1; lvl[1] = 1'b0;
    dur[2] = 2; lvl[2] = 1'b1;
    run(0);

    // Starved after the first symbol, idle high
    n = 1; mode = 1; idle = 1'b1;
    dur[0] = 1; lvl[0] = 1'b0;
    run(1);

    // Abort mid-symbol, then a clean restart
    n = 2; mode = 2; idle = 1'b0; abort_at = 5;
    dur[0] = 3; lvl[0] = 1'b1;
    dur[1] = 1; lvl[1] = 1'b0;
    run(2);
    n = 1; mode = 0; idle = 1'b0;
    dur[0] = 0; lvl[0] = 1'b1;
    run(2);

    for (int r = 0; r < 30; r++) begin
      n    = int'($urandom_range(1, 4));
      mode = int'($urandom_range(0, 2));
      idle = 1'($urandom_range(0, 1));
      for (int i = 0; i < n; i++) begin
        dur[i] = int'($urandom_range(0, 3));
        lvl[i] = 1'($urandom_range(0, 1));
      end
      abort_at = int'($urandom_range(1, 40));
      run(int'($urandom_range(0, 3)));
    end

    // Asynchronous reset while running
    @(negedge clk);
    prescale_i   = 8'd3;
    idle_level_i = 1'b0;
    en_i         = 1'b1;
    sym_valid_i  = 1'b1;
    sym_level_i  = 1'b1;
    sym_dur_i    = 8'd5;
    sym_last_i   = 1'b1;
    @(negedge clk);
    sym_valid_i = 1'b0;
    repeat (3) @(negedge clk);
    #1;
    chk("pre_rst_pin", pulse_out, 1'b1);
    chk("pre_rst_busy", busy_o, 1'b1);
    @(posedge clk);
    #2 sys_rst = 1'b1;
    #1;
    chk("arst_pin", pulse_out, 1'b0);
    chk("arst_busy", busy_o, 1'b0);
    chk("arst_ready", sym_ready_o, 1'b0);
    chk("arst_done", done_o, 1'b0);
    @(negedge clk);
    chk("arst_ready_hold", sym_ready_o, 1'b0);
    sys_rst = 1'b0;
    #1;
    chk("arst_release_ready", sym_ready_o, 1'b1);
    chk("arst_release_pin", pulse_out, 1'b0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
